mux_nch_arb: RTL and testbench
==============================

MUX_NCH_ARB -- requirements
Module: mux_nch_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel, legal range 1..64.
REQ-002 Parameter NCH, default 4, number of input channels, legal range 2..16.
REQ-003 Derived parameter SELW = max(1, ceil(log2(NCH))), width of channel index signals.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  per-channel valid.
REQ-008 in_ready  output  NCH  per-channel ready, combinational, at most one bit high per cycle.
REQ-009 sel  input  SELW  channel select, used when mode=0.
REQ-010 mode  input  1  0 = select mode, 1 = round-robin arbitration mode.
REQ-011 out_data  output  WIDTH  registered data of the accepted word.
REQ-012 out_chan  output  SELW  registered source-channel index of out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accepts the word.

Function
REQ-015 One-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Capacity exists when the register is EMPTY, or when it is FULL with out_ready=1 in the same cycle.
REQ-017 Grant in mode 0: channel sel when sel<NCH and in_valid[sel]=1; otherwise no grant.
REQ-018 Grant in mode 1: first channel with in_valid=1, searching from rr_ptr+1 upward with wrap at NCH-1 to 0.
REQ-019 in_ready[g]=1 only for the granted channel g, and only when capacity exists; all other bits are 0.
REQ-020 Accept: in_valid[g] and in_ready[g] both high; on that edge load out_data=in_data[g], out_chan=g, out_valid=1.
REQ-021 Latency: an accepted word appears on out_data/out_valid exactly 1 cycle after acceptance.
REQ-022 Throughput: one word per cycle when out_ready is held at 1, including accept and drain in the same cycle.
REQ-023 Drain without accept (FULL, out_ready=1, no accept) returns to EMPTY; out_data and out_chan hold their last values.
REQ-024 FULL with out_ready=0: out_data, out_chan and out_valid hold, and all in_ready bits are 0.
REQ-025 rr_ptr (SELW bits) updates to g only on an accept in mode 1; it is unchanged in mode 0 and on idle cycles.
REQ-026 mode and sel are sampled every cycle; a change affects the grant in that same cycle and never disturbs a word already held.
REQ-027 Single valid channel in mode 1 is granted every cycle regardless of rr_ptr.
REQ-028 Fairness in mode 1: with all NCH channels continuously valid and out_ready=1, grants cycle 0,1,...,NCH-1,0,...
REQ-029 Out-of-range sel (non-power-of-2 NCH, sel>=NCH): no grant, all in_ready=0, no error state.

Reset
REQ-030 While rst=1 at a rising edge: out_valid=0, out_data=0, out_chan=0, rr_ptr=NCH-1.
REQ-031 After reset, channel 0 has first round-robin priority.
REQ-032 in_ready is forced to all zeros while rst=1.
REQ-033 Reset mid-operation discards any held word without emitting it.
REQ-034 The first accept is possible on the first edge after rst deasserts.

Verification (WIDTH=8, NCH=4)
REQ-035 Scenario 1, reset: rst=1 for 2 cycles with in_valid=4'hF.
  - Required: out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout.
  - Required: the first mode-1 grant after release is channel 0.
REQ-036 Scenario 2, select mode:
  - Stimulus: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1.
  - Required: in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2, out_valid=1.
REQ-037 Scenario 3, round robin:
  - Stimulus: mode=1, in_valid=4'hF for 8 cycles, out_ready=1.
  - Required: out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
REQ-038 Scenario 4, backpressure:
  - Stimulus: a word from ch1=8'h3C is held FULL, out_ready=0 for 3 cycles, in_valid=4'hF.
  - Required: in_ready=0 and out_data=8'h3C stable for 3 cycles; the next grant after out_ready=1 is channel 2.
REQ-039 Scenario 5, sparse requesters:
  - Stimulus: mode=1, rr_ptr=0, in_valid=4'b1001.
  - Required: grant channel 3, then channel 0, then channel 3 (wrap).
REQ-040 Scenario 6, reset while FULL:
  - Stimulus: out_valid=1 holding 8'h77, rst=1 for 1 cycle.
  - Required: out_valid=0, out_data=0; 8'h77 is never observed with out_ready=1.

Source files
------------

// File: rtl/mux_nch_arb.sv
// mux_nch_arb: N-channel select/round-robin multiplexer feeding a one-entry output register
module mux_nch_arb #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0] chan_q, rr_ptr_q, rr_gnt, gnt, idx;
  logic rr_hit, sel_hit, gnt_ok, cap, accept;
  // Scan from farthest to nearest so the first valid channel after rr_ptr wins
  always_comb begin
    rr_hit = 1'b0;
    rr_gnt = '0;
    idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = SELW'((int'(rr_ptr_q) + k) % NCH);
      if (in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_gnt = idx;
      end
    end
  end
  assign sel_hit = (int'(sel) < NCH) && in_valid[sel];
  assign gnt = mode ? rr_gnt : sel;
  assign gnt_ok = mode ? rr_hit : sel_hit;
  assign cap = (state_q == EMPTY) || out_ready;
  assign in_ready = (!rst && cap && gnt_ok) ? (NCH'(1) << gnt) : '0;
  assign accept = |in_ready;
  assign data_d = in_data[int'(gnt)*WIDTH +: WIDTH];
  // Load on accept, drain to EMPTY when the word leaves with nothing replacing it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      chan_q <= '0;
      rr_ptr_q <= SELW'(NCH - 1);
    end else if (accept) begin
      state_q <= FULL;
      data_q <= data_d;
      chan_q <= gnt;
      if (mode) rr_ptr_q <= gnt;
    end else if (out_ready) begin
      state_q <= EMPTY;
    end
  end
  assign out_valid = (state_q == FULL);
  assign out_data = data_q;
  assign out_chan = chan_q;
endmodule

// File: tb/tb_mux_nch_arb.sv
// tb_mux_nch_arb: directed checks of select mode, round robin, backpressure and reset
module tb_mux_nch_arb;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] in_data;
  logic [3:0] in_valid, in_ready;
  logic [1:0] sel, out_chan;
  logic mode, out_valid, out_ready;
  logic [7:0] out_data;
  int n_chk = 0;
  int n_fail = 0;

  mux_nch_arb #(.WIDTH(8), .NCH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 4'hF;
    mode = 1'b1;
    sel = 2'd0;
    out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_chan", 64'(out_chan), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("first_rr_ready", 64'(in_ready), 64'h1);
    tick();
    chk("first_rr_chan", 64'(out_chan), 64'd0);
    chk("first_rr_data", 64'(out_data), 64'h10);
    chk("first_rr_valid", 64'(out_valid), 64'd1);
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b0100;
    in_data[23:16] = 8'hA5;
    #1;
    chk("sel_ready", 64'(in_ready), 64'h4);
    tick();
    chk("sel_data", 64'(out_data), 64'hA5);
    chk("sel_chan", 64'(out_chan), 64'd2);
    chk("sel_valid", 64'(out_valid), 64'd1);
    sel = 2'd1;
    #1;
    chk("sel_idle_ready", 64'(in_ready), 64'h0);
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data_hold", 64'(out_data), 64'hA5);
    chk("drain_chan_hold", 64'(out_chan), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 1'b1;
    in_valid = 4'hF;
    in_data[23:16] = 8'h12;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_chan", 64'(out_chan), 64'(i % 4));
      chk("rr_data", 64'(out_data), 64'(8'h10 + i % 4));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end
    in_data[15:8] = 8'h3C;
    in_valid = 4'b0010;
    tick();
    chk("bp_load_data", 64'(out_data), 64'h3C);
    chk("bp_load_chan", 64'(out_chan), 64'd1);
    out_ready = 1'b0;
    in_valid = 4'hF;
    #1;
    chk("bp_ready", 64'(in_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", 64'(in_ready), 64'h0);
      chk("bp_hold_data", 64'(out_data), 64'h3C);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_next_ready", 64'(in_ready), 64'h4);
    tick();
    chk("bp_next_chan", 64'(out_chan), 64'd2);
    chk("bp_next_data", 64'(out_data), 64'h12);
    in_valid = 4'b0001;
    tick();
    chk("sparse_pre_chan", 64'(out_chan), 64'd0);
    in_valid = 4'b1001;
    #1;
    chk("sparse_ready0", 64'(in_ready), 64'h8);
    tick();
    chk("sparse_chan0", 64'(out_chan), 64'd3);
    chk("sparse_ready1", 64'(in_ready), 64'h1);
    tick();
    chk("sparse_chan1", 64'(out_chan), 64'd0);
    chk("sparse_ready2", 64'(in_ready), 64'h8);
    tick();
    chk("sparse_chan2", 64'(out_chan), 64'd3);
    in_valid = 4'b0001;
    in_data[7:0] = 8'h77;
    tick();
    chk("rf_load_data", 64'(out_data), 64'h77);
    chk("rf_load_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    in_valid = 4'hF;
    #1;
    chk("rf_rst_ready", 64'(in_ready), 64'h0);
    tick();
    chk("rf_valid", 64'(out_valid), 64'd0);
    chk("rf_data", 64'(out_data), 64'd0);
    chk("rf_chan", 64'(out_chan), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    in_data[7:0] = 8'h10;
    #1;
    chk("rf_after_ready", 64'(in_ready), 64'h1);
    tick();
    chk("rf_after_chan", 64'(out_chan), 64'd0);
    chk("rf_after_data", 64'(out_data), 64'h10);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
